// File: rtl/pyrxsco_pkg.sv
// Shared constants and types for the SCO receive ping-pong buffer arbiter.
// Bank geometry, counter width and the interval FSM encoding live here.
package pyrxsco_pkg;

  localparam int BANK_WORDS = 128;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;

  typedef enum logic {
    WAIT_SCO = 1'b0,
    RUN      = 1'b1
  } sco_state_e;

  typedef enum logic {
    GNT_BSM    = 1'b0,
    GNT_LNCTRL = 1'b1
  } gnt_side_e;

endpackage

// File: rtl/sram256x32_1p.sv
// Single-port synchronous SRAM model: write or read when cs is high,
// read data appears on rdata the cycle after a read access.
module sram256x32_1p
  import pyrxsco_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = pyrxsco_pkg::DATA_W
) (
  input  logic          clk_6M,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_6M) begin
    if (cs) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/pyrxsco_bufarb.sv
// SCO receive buffer arbiter: BSM writes one bank while the link controller
// reads the other; banks swap on each SCO interval strobe.
module pyrxsco_bufarb
  import pyrxsco_pkg::*;
#(
  parameter int BANK_WORDS = pyrxsco_pkg::BANK_WORDS,
  parameter int DATA_W     = pyrxsco_pkg::DATA_W
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              sco_en,
  input  logic              tsco_p,
  input  logic              bsm_req,
  input  logic [DATA_W-1:0] bsm_wdata,
  output logic              bsm_gnt,
  input  logic              lnctrl_req,
  output logic              lnctrl_gnt,
  output logic [DATA_W-1:0] lnctrl_rdata,
  output logic              lnctrl_rvalid,
  output logic [ADDR_W-1:0] rd_avail,
  output logic              ovf,
  output logic              udf,
  input  logic              flag_clr,
  output sco_state_e        dbg_state
);

  localparam logic [ADDR_W-1:0] BANK_MAX = ADDR_W'(BANK_WORDS);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  sco_state_e        state;
  gnt_side_e         last_gnt;
  logic              wb;
  logic              sco_en_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] rcnt;
  logic              rvalid_q;

  logic              abort;
  logic              swap;
  logic              wr_full;
  logic              rd_empty;
  logic              wr_elig;
  logic              rd_elig;
  logic              ovf_set;
  logic              udf_set;

  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;

  assign abort    = sco_en_q & ~sco_en;
  assign swap     = sco_en & tsco_p;
  assign wr_full  = (wptr == BANK_MAX);
  assign rd_empty = (rptr == rcnt);
  assign ovf_set  = bsm_req & wr_full;
  assign udf_set  = lnctrl_req & rd_empty;

  // Requests are held-request/same-cycle-grant: a requester presents req
  // (and wdata) and the transfer happens in exactly the cycle its gnt is high;
  // an ungranted request is not remembered. Read data follows one cycle later
  // qualified by lnctrl_rvalid.
  assign wr_elig = rstz & bsm_req & ~wr_full & ~abort;
  assign rd_elig = rstz & lnctrl_req & ~rd_empty & sco_en & (state == RUN);

  // Round-robin: under contention the side not granted last wins.
  assign bsm_gnt    = wr_elig & (~rd_elig | (last_gnt == GNT_LNCTRL));
  assign lnctrl_gnt = rd_elig & (~wr_elig | (last_gnt == GNT_BSM));

  assign sram_cs   = bsm_gnt | lnctrl_gnt;
  assign sram_we   = bsm_gnt;
  assign sram_addr = bsm_gnt ? {wb, wptr[ADDR_W-2:0]} : {~wb, rptr[ADDR_W-2:0]};

  assign lnctrl_rvalid = rvalid_q;
  assign lnctrl_rdata  = rvalid_q ? sram_rdata : '0;
  assign rd_avail      = (state == RUN) ? (rcnt - rptr) : '0;
  assign dbg_state     = state;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state    <= WAIT_SCO;
      last_gnt <= GNT_LNCTRL;
      wb       <= 1'b0;
      sco_en_q <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      rcnt     <= '0;
      rvalid_q <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      sco_en_q <= sco_en;
      rvalid_q <= lnctrl_gnt & ~abort;
      ovf      <= ovf_set | (ovf & ~flag_clr);
      udf      <= udf_set | (udf & ~flag_clr);

      if (bsm_gnt) begin
        last_gnt <= GNT_BSM;
      end else if (lnctrl_gnt) begin
        last_gnt <= GNT_LNCTRL;
      end

      case (state)
        WAIT_SCO: begin
          if (abort) begin
            wptr <= '0;
            rptr <= '0;
            rcnt <= '0;
          end else if (swap) begin
            state <= RUN;
            wb    <= ~wb;
            rcnt  <= wptr + ADDR_W'(bsm_gnt);
            wptr  <= '0;
            rptr  <= '0;
          end else if (bsm_gnt) begin
            wptr <= wptr + ONE;
          end
        end
        RUN: begin
          if (!sco_en) begin
            state <= WAIT_SCO;
            wptr  <= '0;
            rptr  <= '0;
            rcnt  <= '0;
          end else if (swap) begin
            // A grant in the strobe cycle uses the old banks; the write is
            // folded into the new read count.
            wb   <= ~wb;
            rcnt <= wptr + ADDR_W'(bsm_gnt);
            wptr <= '0;
            rptr <= '0;
          end else begin
            if (bsm_gnt) begin
              wptr <= wptr + ONE;
            end
            if (lnctrl_gnt) begin
              rptr <= rptr + ONE;
            end
          end
        end
        default: state <= WAIT_SCO;
      endcase
    end
  end

  sram256x32_1p #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_sram (
    .clk_6M (clk_6M),
    .cs     (sram_cs),
    .we     (sram_we),
    .addr   (sram_addr),
    .wdata  (bsm_wdata),
    .rdata  (sram_rdata)
  );

endmodule

// File: tb/tb_pyrxsco_bufarb.sv
// Directed bench for pyrxsco_bufarb: grants are checked each cycle, read data
// is checked against an expected queue filled when a read is granted.
module tb_pyrxsco_bufarb;
  import pyrxsco_pkg::*;

  logic              clk_6M;
  logic              rstz;
  logic              sco_en;
  logic              tsco_p;
  logic              bsm_req;
  logic [DATA_W-1:0] bsm_wdata;
  logic              bsm_gnt;
  logic              lnctrl_req;
  logic              lnctrl_gnt;
  logic [DATA_W-1:0] lnctrl_rdata;
  logic              lnctrl_rvalid;
  logic [ADDR_W-1:0] rd_avail;
  logic              ovf;
  logic              udf;
  logic              flag_clr;
  sco_state_e        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  pyrxsco_bufarb dut (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .sco_en        (sco_en),
    .tsco_p        (tsco_p),
    .bsm_req       (bsm_req),
    .bsm_wdata     (bsm_wdata),
    .bsm_gnt       (bsm_gnt),
    .lnctrl_req    (lnctrl_req),
    .lnctrl_gnt    (lnctrl_gnt),
    .lnctrl_rdata  (lnctrl_rdata),
    .lnctrl_rvalid (lnctrl_rvalid),
    .rd_avail      (rd_avail),
    .ovf           (ovf),
    .udf           (udf),
    .flag_clr      (flag_clr),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk_6M = 1'b0;
    forever #83 clk_6M = ~clk_6M;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of stimulus at the falling edge, settle, then return
  task automatic cyc(input logic br, input logic [31:0] wd, input logic lr, input logic ts);
    @(negedge clk_6M);
    bsm_req    = br;
    bsm_wdata  = wd;
    lnctrl_req = lr;
    tsco_p     = ts;
    flag_clr   = 1'b0;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  // scoreboard: every rvalid must match the oldest expected word
  always @(posedge clk_6M) begin
    #1;
    if (lnctrl_rvalid) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
      else check("rdata", lnctrl_rdata, exp_q.pop_front());
    end
  end

  initial begin
    rstz = 1'b0; sco_en = 1'b0; tsco_p = 1'b0; bsm_req = 1'b0; bsm_wdata = '0;
    lnctrl_req = 1'b0; flag_clr = 1'b0;
    repeat (2) @(negedge clk_6M);
    #1;
    check("rst_bsm_gnt", bsm_gnt, 0);
    check("rst_lnctrl_gnt", lnctrl_gnt, 0);
    check("rst_rdata", lnctrl_rdata, 0);
    check("rst_rvalid", lnctrl_rvalid, 0);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    check("rst_state", dbg_state, WAIT_SCO);
    @(negedge clk_6M);
    rstz = 1'b1;
    sco_en = 1'b1;

    // basic ping-pong: 3 writes, swap, 3 reads
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'hA000_0000 + i, 0, 0);
      if (i == 0) check("run_state", dbg_state, RUN);
      check("wr_gnt_a", bsm_gnt, 1);
    end
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      check("rd_avail_a", rd_avail, 3 - i);
      check("rd_gnt_a", lnctrl_gnt, 1);
      exp_q.push_back(32'hA000_0000 + i);
    end
    idle();
    check("rd_avail_a_end", rd_avail, 0);
    check("q_empty_a", exp_q.size(), 0);

    // round-robin under contention
    for (int i = 0; i < 6; i++) cyc(1, 32'hB000_0000 + i, 0, 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    check("rd_gnt_b0", lnctrl_gnt, 1);
    exp_q.push_back(32'hB000_0000);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'hC000_0000 + i / 2, 1, 0);
      check("rr_bsm_gnt", bsm_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_lnctrl_gnt", lnctrl_gnt, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) exp_q.push_back(32'hB000_0001 + i / 2);
    end
    idle();
    check("rd_avail_rr", rd_avail, 2);

    // write granted in the swap cycle lands in the old bank
    cyc(1, 32'hD000_0000, 0, 1);
    check("swap_wr_gnt", bsm_gnt, 1);
    idle();
    check("rd_avail_swap", rd_avail, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0);
      check("rd_gnt_swap", lnctrl_gnt, 1);
      exp_q.push_back((i < 3) ? (32'hC000_0000 + i) : 32'hD000_0000);
    end

    // overflow: 128 accepted, 129th dropped
    for (int i = 0; i < 129; i++) begin
      cyc(1, 32'hE000_0000 + i, 0, 0);
      if (i == 0 || i == 127 || i == 128) check("ovf_wr_gnt", bsm_gnt, (i < 128) ? 1 : 0);
    end
    idle();
    check("ovf_set", ovf, 1);
    cyc(1, '0, 0, 0);
    flag_clr = 1'b1;
    #1;
    check("ovf_full_gnt", bsm_gnt, 0);
    idle();
    check("ovf_set_wins", ovf, 1);
    idle();
    flag_clr = 1'b1;
    idle();
    check("ovf_clr", ovf, 0);
    cyc(0, '0, 0, 1);
    idle();
    check("rd_avail_full", rd_avail, 128);
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 1, 0);
      exp_q.push_back(32'hE000_0000 + i);
    end
    idle();
    check("rd_avail_126", rd_avail, 126);

    // underflow on empty read bank
    cyc(0, '0, 0, 1);
    idle();
    check("rd_avail_empty", rd_avail, 0);
    cyc(0, '0, 1, 0);
    check("udf_gnt", lnctrl_gnt, 0);
    idle();
    check("udf_set", udf, 1);
    flag_clr = 1'b1;
    idle();
    check("udf_clr", udf, 0);

    // sco_en drop mid-interval
    cyc(1, 32'hF000_0000, 0, 0);
    cyc(1, 32'hF000_0001, 0, 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    check("rd_gnt_f0", lnctrl_gnt, 1);
    exp_q.push_back(32'hF000_0000);
    cyc(0, '0, 1, 0);
    sco_en = 1'b0;
    #1;
    check("abort_gnt", lnctrl_gnt, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      check("abort_state", dbg_state, WAIT_SCO);
      check("abort_rd_avail", rd_avail, 0);
      check("abort_rd_gnt", lnctrl_gnt, 0);
    end
    check("q_empty_abort", exp_q.size(), 0);

    // reset pulse during reads
    idle();
    sco_en = 1'b1;
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'h1000_0000 + i, 0, 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    check("rd_gnt_g0", lnctrl_gnt, 1);
    exp_q.push_back(32'h1000_0000);
    @(negedge clk_6M);
    rstz = 1'b0;
    #1;
    check("rstp_bsm_gnt", bsm_gnt, 0);
    check("rstp_lnctrl_gnt", lnctrl_gnt, 0);
    check("rstp_rdata", lnctrl_rdata, 0);
    check("rstp_rvalid", lnctrl_rvalid, 0);
    check("rstp_rd_avail", rd_avail, 0);
    check("rstp_ovf", ovf, 0);
    check("rstp_udf", udf, 0);
    @(negedge clk_6M);
    rstz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      check("post_rst_rd_gnt", lnctrl_gnt, 0);
    end
    cyc(1, 32'h2000_0000, 0, 0);
    check("post_rst_wr_gnt", bsm_gnt, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    check("post_rst_rd_avail", rd_avail, 1);
    check("post_rst_rd_gnt_h0", lnctrl_gnt, 1);
    exp_q.push_back(32'h2000_0000);
    idle();
    idle();
    check("q_empty_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
